clk_div_gen: RTL and testbench
==============================

Name: clk_div_gen

Overview:
- Multi-channel, runtime-programmable clock divider and tick generator. Parametrised successor of the fixed single-channel divider.
- Each channel produces a 50%-duty divided clock (clk_out) and a one-cycle rising-edge strobe (tick), for use by camera/HDMI timing logic.
- Divisors can be reprogrammed while running; a new divisor takes effect only at a half-period boundary, so no runt pulses occur.

Parameters:
- NUM_CH, 2, number of independent divider channels (1..8).
- CNT_W, 16, width of each channel's counter and divisor.
- DEFAULT_DIV, 50, divisor loaded into every channel at reset; must fit in CNT_W bits.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  NUM_CH  per-channel run enable.
- div_in  input  NUM_CH*CNT_W  per-channel divisor; channel k uses bits [k*CNT_W +: CNT_W].
- div_load  input  NUM_CH  per-channel one-cycle strobe that captures div_in into the pending register.
- clk_out  output  NUM_CH  divided clocks (registered).
- tick  output  NUM_CH  one-cycle pulse, asserted in the same cycle clk_out rises.
- pend  output  NUM_CH  high while a loaded divisor is waiting to be applied.

Behaviour:
- Reset (reset=1 at a clk_in edge), per channel:
  - cnt=0, div_act=DEFAULT_DIV, div_pend=0, pend=0, clk_out=0, tick=0.
  - Reset overrides all other inputs, including a div_load in the same cycle.
  - Reset mid-period discards the partial period and any pending divisor.
- Running (en=1):
  - cnt increments by 1 each cycle.
  - When cnt==div_act (the terminal count): cnt goes to 0, clk_out toggles, and any pending divisor is applied.
  - Half-period is div_act+1 cycles; full period is 2*(div_act+1) cycles.
  - div_act=0 gives clk_in/2.
- tick:
  - tick=1 exactly in the cycle clk_out goes 0->1, otherwise 0.
  - tick is registered alongside clk_out, with no extra latency.
- Disabled (en=0):
  - Next cycle: cnt=0, clk_out=0, tick=0.
  - If pend=1, div_pend is copied to div_act and pend clears.
  - On re-enable, the first rise occurs after div_act+1 cycles of low.
- Divisor load:
  - div_load[k]=1 captures div_in into div_pend and sets pend.
  - A new div_load while pend=1 overwrites div_pend; the last value wins.
  - div_load coinciding with a terminal count: the newly captured value becomes pending; the old pending value (if any) is applied at that terminal count.
- Terminal count recomputation: if div_act changes while cnt>div_act (possible only via the disabled path), the comparison is cnt>=div_act, so the counter never wraps through 2^CNT_W.
- Arithmetic: cnt is unsigned CNT_W bits, and the increment cannot overflow because of the >= compare.
- Channels are fully independent; there is no cross-channel phase relation unless the optional feature below is compiled in.

Optional Feature:
- Macro: CLK_DIV_GEN_SYNC_EN.
- With the macro defined:
  - Extra input port sync_in (1 bit).
  - sync_in=1 forces every enabled channel to cnt=0, clk_out=0, tick=0 in the next cycle, and applies any pending divisor.
  - Net effect: channels are phase-aligned; their first rise occurs div_act+1 cycles later.
  - Reset has priority over sync_in; sync_in has priority over a terminal count in the same cycle.
- Without the macro: no sync_in port, and there is no way to realign channels other than reset or toggling en.

Decomposition:
- Package clk_div_gen_pkg holds:
  - default constants DEF_CNT_W=16 and DEF_DIV=50;
  - typedef div_t (logic [DEF_CNT_W-1:0]);
  - MAX_CH=8.
- Sub-module clk_div_chan implements one channel (cnt, div_act, div_pend, pend, clk_out, tick).
- clk_div_gen is a generate loop over NUM_CH instances plus port slicing.

Test Plan:
- Reset release, en=1, DEFAULT_DIV=50 -> first clk_out rise and tick 51 cycles after release; period 102 cycles; tick high exactly 1 cycle per period.
- div_in=3 with div_load pulsed mid-half-period -> pend=1 until the next terminal count; then half-period becomes 4 cycles (period 8), with no half-period shorter than 4.
- div_in=0 loaded, then en toggled 1->0->1 -> pend clears during disable; clk_out=0 while disabled; after re-enable it toggles every cycle (clk_in/2).
- Two div_loads (7 then 9) before the terminal count -> only 9 is applied (half-period 10); 7 is never observed.
- reset asserted mid-period with pend=1 -> next cycle clk_out=0, tick=0, pend=0, div_act=50.
- CLK_DIV_GEN_SYNC_EN: ch0 div=4, ch1 div=9, running out of phase; pulse sync_in -> both low next cycle; ch0 rises 5 cycles later, ch1 rises 10 cycles later, both measured from the same edge.

Source files
------------

// File: rtl/clk_div_gen_pkg.sv
// Shared defaults and types for the clk_div_gen multi-channel clock divider.
package clk_div_gen_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_DIV   = 50;
    localparam int MAX_CH    = 8;

    typedef logic [DEF_CNT_W-1:0] div_t;

endpackage

// File: rtl/clk_div_chan.sv
// One clock-divider channel: 50% duty divided clock, rising-edge tick, glitch-free divisor reload.
// Optional CLK_DIV_GEN_SYNC_EN adds sync_in to phase-align channels.
module clk_div_chan
    import clk_div_gen_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
`ifdef CLK_DIV_GEN_SYNC_EN
    input  logic             sync_in,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             restart;
    logic             term;

`ifdef CLK_DIV_GEN_SYNC_EN
    assign restart = ~en | sync_in;
`else
    assign restart = ~en;
`endif

    // >= rather than == so a shrunken divisor can never let cnt run past it
    assign term = (cnt_q >= div_act_q);

    always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;

        if (restart || term) begin
            cnt_d = '0;
            if (pend_q) begin
                div_act_d = div_pend_q;
                pend_d    = 1'b0;
            end
            if (restart) begin
                clk_out_d = 1'b0;
            end else begin
                clk_out_d = ~clk_out_q;
                tick_d    = ~clk_out_q;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // A load in the same cycle as an apply becomes the next pending value
        if (div_load) begin
            div_pend_d = div_in;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_q      <= '0;
            div_act_q  <= DIV_RST;
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign pend    = pend_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel runtime-programmable clock divider / tick generator (NUM_CH independent channels).
// Optional CLK_DIV_GEN_SYNC_EN adds sync_in, which realigns all enabled channels.
module clk_div_gen
    import clk_div_gen_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*CNT_W-1:0] div_in,
    input  logic [NUM_CH-1:0]       div_load,
`ifdef CLK_DIV_GEN_SYNC_EN
    input  logic                    sync_in,
`endif
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       pend
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_in   (clk_in),
            .reset    (reset),
            .en       (en[k]),
            .div_in   (div_in[k*CNT_W +: CNT_W]),
            .div_load (div_load[k]),
`ifdef CLK_DIV_GEN_SYNC_EN
            .sync_in  (sync_in),
`endif
            .clk_out  (clk_out[k]),
            .tick     (tick[k]),
            .pend     (pend[k])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: event-scheduled reference model plus directed timing checks.
module tb_clk_div_gen;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 16;
    localparam int DEF    = 50;

    logic                    clk_in = 1'b0;
    logic                    reset;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH*CNT_W-1:0] div_in;
    logic [NUM_CH-1:0]       div_load;
    logic                    sync_in;
    logic [NUM_CH-1:0]       clk_out, tick, pend;

    int tests = 0;
    int fails = 0;

    clk_div_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
`ifdef CLK_DIV_GEN_SYNC_EN
        .sync_in  (sync_in),
`endif
        .clk_out  (clk_out),
        .tick     (tick),
        .pend     (pend)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: each channel schedules its next toggle as an absolute cycle number.
    longint cyc = 0;
    bit     m_valid = 0;
    bit     m_lvl [NUM_CH];
    bit     m_tick[NUM_CH];
    bit     m_pend[NUM_CH];
    int     m_div [NUM_CH];
    int     m_pdiv[NUM_CH];
    longint m_next[NUM_CH];

    always @(posedge clk_in) begin
        cyc++;
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) begin
                m_lvl[c]  = 0;
                m_tick[c] = 0;
                m_pend[c] = 0;
                m_div[c]  = DEF;
                m_next[c] = cyc + DEF + 1;
            end else begin
                m_tick[c] = 0;
                if (!en[c] || sync_in || cyc == m_next[c]) begin
                    if (!en[c] || sync_in) begin
                        m_lvl[c] = 0;
                    end else begin
                        m_lvl[c]  = !m_lvl[c];
                        m_tick[c] = m_lvl[c];
                    end
                    if (m_pend[c]) begin
                        m_div[c]  = m_pdiv[c];
                        m_pend[c] = 0;
                    end
                    m_next[c] = cyc + m_div[c] + 1;
                end
                if (div_load[c]) begin
                    m_pdiv[c] = int'(div_in[c*CNT_W +: CNT_W]);
                    m_pend[c] = 1;
                end
            end
        end
        if (reset) m_valid = 1;
    end

    always @(negedge clk_in) begin
        if (m_valid) begin
            for (int c = 0; c < NUM_CH; c++) begin
                tests++;
                if (clk_out[c] !== m_lvl[c] || tick[c] !== m_tick[c] || pend[c] !== m_pend[c]) begin
                    fails++;
                    $display("FAIL model ch%0d cyc=%0d got clk_out/tick/pend=%b%b%b want %b%b%b",
                             c, cyc, clk_out[c], tick[c], pend[c], m_lvl[c], m_tick[c], m_pend[c]);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic set_div(input int c, input int val);
        div_in[c*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    // Counts negedges until tick[c] is seen; n=1 is the first edge after the call.
    task automatic wait_tick(input int c, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!tick[c] && n < budget);
        if (!tick[c]) begin
            tests++;
            fails++;
            $display("FAIL tick_timeout ch%0d got=none want=tick within %0d", c, budget);
        end
    endtask

    task automatic wait_pend_clear(input int c, input int budget);
        int n = 0;
        while (pend[c] && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        if (pend[c]) begin
            tests++;
            fails++;
            $display("FAIL pend_timeout ch%0d got=1 want=0 within %0d", c, budget);
        end
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        en       = '0;
        div_in   = '0;
        div_load = '0;
        sync_in  = 1'b0;
        repeat (3) @(negedge clk_in);
        check("reset_clk_out", int'(clk_out), 0);
        check("reset_tick",    int'(tick),    0);
        check("reset_pend",    int'(pend),    0);

        // Default divisor: first rise 51 cycles after release, period 102
        reset = 1'b0;
        en    = 2'b11;
        wait_tick(0, 200, n);
        check("first_rise_51", n, 51);
        check("ch1_first_rise_same", int'(tick[1]), 1);
        wait_tick(0, 200, n);
        check("period_102", n, 102);

        // ch0 -> divisor 3 loaded mid half-period
        set_div(0, 3);
        div_load = 2'b01;
        @(negedge clk_in);
        div_load = '0;
        check("pend_after_load", int'(pend[0]), 1);
        wait_pend_clear(0, 200);
        check("fall_at_apply", int'(clk_out[0]), 0);
        wait_tick(0, 50, n);
        check("half_period_4", n, 4);
        wait_tick(0, 50, n);
        check("period_8", n, 8);

        // ch1 -> divisor 0 applied through disable, then clk_in/2
        set_div(1, 0);
        div_load = 2'b10;
        @(negedge clk_in);
        div_load = '0;
        en       = 2'b01;
        check("ch1_pend_set", int'(pend[1]), 1);
        @(negedge clk_in);
        check("ch1_pend_clear_disabled", int'(pend[1]), 0);
        check("ch1_low_disabled", int'(clk_out[1]), 0);
        repeat (2) @(negedge clk_in);
        check("ch1_still_low", int'(clk_out[1]), 0);
        en = 2'b11;
        wait_tick(1, 10, n);
        check("ch1_div0_first_rise", n, 1);
        wait_tick(1, 10, n);
        check("ch1_div0_period_2", n, 2);

        // ch0: loads 7 then 9 before the terminal count; only 9 takes effect
        wait_tick(0, 50, n);
        set_div(0, 7);
        div_load = 2'b01;
        @(negedge clk_in);
        set_div(0, 9);
        @(negedge clk_in);
        div_load = '0;
        check("pend_two_loads", int'(pend[0]), 1);
        wait_pend_clear(0, 50);
        wait_tick(0, 50, n);
        check("last_load_wins_half_10", n, 10);
        wait_tick(0, 50, n);
        check("last_load_wins_period_20", n, 20);

        // Reset mid-period with a pending divisor and a coincident load
        repeat (5) @(negedge clk_in);
        set_div(0, 5);
        div_load = 2'b01;
        @(negedge clk_in);
        check("pend_before_reset", int'(pend[0]), 1);
        set_div(0, 12);
        set_div(1, 12);
        div_load = 2'b11;
        reset    = 1'b1;
        @(negedge clk_in);
        reset    = 1'b0;
        div_load = '0;
        check("mid_reset_clk_out", int'(clk_out), 0);
        check("mid_reset_tick",    int'(tick),    0);
        check("mid_reset_pend",    int'(pend),    0);
        wait_tick(0, 200, n);
        check("after_reset_rise_51", n, 51);

`ifdef CLK_DIV_GEN_SYNC_EN
        begin
            int t0, t1;
            set_div(0, 4);
            set_div(1, 9);
            div_load = 2'b11;
            @(negedge clk_in);
            div_load = '0;
            en       = 2'b00;
            @(negedge clk_in);
            en = 2'b11;
            repeat (23) @(negedge clk_in);
            sync_in = 1'b1;
            @(negedge clk_in);
            sync_in = 1'b0;
            check("sync_clk_out_low", int'(clk_out), 0);
            check("sync_tick_low",    int'(tick),    0);
            t0 = 0;
            t1 = 0;
            for (int i = 1; i <= 30; i++) begin
                @(negedge clk_in);
                if (tick[0] && t0 == 0) t0 = i;
                if (tick[1] && t1 == 0) t1 = i;
            end
            check("sync_ch0_rise_5",  t0, 5);
            check("sync_ch1_rise_10", t1, 10);
        end
`endif

        repeat (4) @(negedge clk_in);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
